// File: rtl/spm_pkg.sv
// -----------------------------------------------------------------------------
// spm_pkg
// Shared definitions for the serial-parallel multiplier controller.
//   spm_state_t  : controller FSM state encoding (also exported on dbg_state)
//   spm_cycles() : number of serial shift cycles for a given operand width
// -----------------------------------------------------------------------------
package spm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } spm_state_t;

    // A WIDTH x WIDTH signed product needs 2*WIDTH serial bits.
    function automatic int spm_cycles(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/spm_bit_counter.sv
// -----------------------------------------------------------------------------
// spm_bit_counter
// Modulo-MODULUS up-counter that indexes the serial bit position.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset (count -> 0)
//   i_en     : advance the count by one
//   i_clr    : synchronous clear, wins over i_en
//   o_count  : current bit index, 0 .. MODULUS-1
//   o_tc     : high while the count sits at MODULUS-1
// -----------------------------------------------------------------------------
module spm_bit_counter #(
    parameter int MODULUS = 16,
    parameter int CW      = $clog2(MODULUS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_en,
    input  logic          i_clr,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_count;
    logic          w_tc;

    assign w_tc    = (r_count == CW'(MODULUS - 1));
    assign o_count = r_count;
    assign o_tc    = w_tc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            // Wrap at terminal count so the next operation starts at bit 0.
            r_count <= w_tc ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/spm_ctrl.sv
// -----------------------------------------------------------------------------
// spm_ctrl
// Controller for a serial-parallel multiplier (SPM) datapath. The multiplicand
// is held in parallel on x_par, the multiplier is streamed LSB first on y_bit
// (sign-extended to 2*WIDTH bits), and the datapath returns the product LSB
// first on p_bit, which is collected into product.
//
// Handshake: ready is high only in IDLE; a cycle with start=1 and ready=1 is
// the accept edge. done pulses for one cycle 2*WIDTH+2 cycles later, in the
// same cycle the new product first appears. start is ignored while ready=0.
//
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   start      : request a multiplication (taken only when ready=1)
//   abort      : (only with SPM_CTRL_ABORT_EN) drop the operation in LOAD/RUN
//   a_in, b_in : signed multiplicand / multiplier, latched on accept
//   ready      : controller idle
//   done       : one-cycle product-valid pulse
//   product    : signed 2*WIDTH result, updated only on completion
//   spm_load   : datapath clear strobe (LOAD state)
//   spm_en     : datapath shift enable (RUN state)
//   x_par      : latched multiplicand
//   y_bit      : serial multiplier bit for the current RUN cycle
//   p_bit      : serial product bit from the datapath
//   dbg_state  : current FSM state
//
// Build option: define SPM_CTRL_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module spm_ctrl
    import spm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef SPM_CTRL_ABORT_EN
    input  logic               abort,
`endif
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               spm_load,
    output logic               spm_en,
    output logic [WIDTH-1:0]   x_par,
    output logic               y_bit,
    input  logic               p_bit,
    output spm_state_t         dbg_state
);

    localparam int N  = spm_cycles(WIDTH);
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(WIDTH);

    spm_state_t          r_state;
    spm_state_t          w_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [2*WIDTH-1:0]  r_shift;
    logic [2*WIDTH-1:0]  r_product;
    logic [CW-1:0]       w_idx;
    logic                w_tc;
    logic [IW-1:0]       w_sel;
    logic                w_abort;
    logic                w_abort_act;
    logic                w_accept;
    logic                w_finish;
    logic [2*WIDTH-1:0]  w_shift_next;

`ifdef SPM_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_abort_act = w_abort && ((r_state == S_LOAD) || (r_state == S_RUN));
    assign w_finish    = (r_state == S_RUN) && w_tc && !w_abort_act;

    spm_bit_counter #(
        .MODULUS (N),
        .CW      (CW)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .i_en    (r_state == S_RUN),
        .i_clr   (w_accept || w_abort_act),
        .o_count (w_idx),
        .o_tc    (w_tc)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and strobes
    always_comb begin
        w_next   = r_state;
        ready    = 1'b0;
        done     = 1'b0;
        spm_load = 1'b0;
        spm_en   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                spm_load = 1'b1;
                w_next   = w_abort_act ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                spm_en = 1'b1;
                // Abort outranks terminal count.
                if (w_abort_act) begin
                    w_next = S_IDLE;
                end else if (w_tc) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Past bit WIDTH-1 the multiplier's sign bit is repeated.
    assign w_sel = (w_idx < CW'(WIDTH)) ? w_idx[IW-1:0] : IW'(WIDTH - 1);
    assign y_bit = (r_state == S_RUN) ? r_b[w_sel] : 1'b0;

    // Product bits arrive LSB first, so they enter at the MSB and move right.
    assign w_shift_next = {p_bit, r_shift[2*WIDTH-1:1]};

    // Operand latches and product collection. The visible product is only
    // replaced when an operation completes, so an aborted run leaves the
    // previous result intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_shift   <= '0;
            r_product <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= a_in;
                r_b     <= b_in;
                r_shift <= '0;
            end
            if ((r_state == S_RUN) && !w_abort_act) begin
                r_shift <= w_shift_next;
            end
            if (w_finish) begin
                r_product <= w_shift_next;
            end
        end
    end

    assign x_par     = r_a;
    assign product   = r_product;
    assign dbg_state = r_state;

endmodule
